// File: rtl/alu_op_scheduler.sv
// Shares one ALU between two requesters over valid/ready handshakes.
// Define ALU_SCHED_FIXED_PRIO_EN for fixed priority (REQ0 wins) instead of round-robin.
module alu_op_scheduler #(
   parameter int WIDTH   = 16,
   parameter int ALU_LAT = 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             REQ0_VALID,
   output logic             REQ0_READY,
   input  logic [3:0]       REQ0_FUN,
   input  logic [WIDTH-1:0] REQ0_A,
   input  logic [WIDTH-1:0] REQ0_B,
   input  logic             REQ1_VALID,
   output logic             REQ1_READY,
   input  logic [3:0]       REQ1_FUN,
   input  logic [WIDTH-1:0] REQ1_A,
   input  logic [WIDTH-1:0] REQ1_B,
   output logic [3:0]       ALU_FUN,
   output logic [WIDTH-1:0] ALU_A,
   output logic [WIDTH-1:0] ALU_B,
   output logic             ALU_EN,
   input  logic [WIDTH-1:0] ALU_OUT,
   output logic             RES_VALID,
   input  logic             RES_READY,
   output logic [WIDTH-1:0] RES_DATA,
   output logic             RES_ID
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t           state_q, state_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [3:0]       fun_q, fun_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             id_q, id_d;
   logic [WIDTH-1:0] res_data_q, res_data_d;
   logic             res_id_q, res_id_d;
   logic             gnt1;
   logic             hs;

`ifndef ALU_SCHED_FIXED_PRIO_EN
   logic             last_q, last_d;
`endif

   // Pick the requester that would win a handshake this cycle
   always_comb begin
      gnt1 = 1'b0;
`ifdef ALU_SCHED_FIXED_PRIO_EN
      gnt1 = ~REQ0_VALID & REQ1_VALID;
`else
      if (REQ0_VALID && REQ1_VALID) begin
         gnt1 = ~last_q;
      end else begin
         gnt1 = ~REQ0_VALID & REQ1_VALID;
      end
`endif
   end

   // Next-state, handshake and datapath capture
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      fun_d      = fun_q;
      a_d        = a_q;
      b_d        = b_q;
      id_d       = id_q;
      res_data_d = res_data_q;
      res_id_d   = res_id_q;
`ifndef ALU_SCHED_FIXED_PRIO_EN
      last_d     = last_q;
`endif
      REQ0_READY = 1'b0;
      REQ1_READY = 1'b0;
      ALU_EN     = 1'b0;
      RES_VALID  = 1'b0;
      hs         = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            REQ0_READY = REQ0_VALID & ~gnt1;
            REQ1_READY = REQ1_VALID & gnt1;
            hs         = REQ0_READY | REQ1_READY;
            if (hs) begin
               fun_d   = gnt1 ? REQ1_FUN : REQ0_FUN;
               a_d     = gnt1 ? REQ1_A : REQ0_A;
               b_d     = gnt1 ? REQ1_B : REQ0_B;
               id_d    = gnt1;
`ifndef ALU_SCHED_FIXED_PRIO_EN
               last_d  = gnt1;
`endif
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            ALU_EN  = 1'b1;
            cnt_d   = 3'(ALU_LAT);
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (cnt_q == 3'd1) begin
               res_data_d = ALU_OUT;
               res_id_d   = id_q;
               cnt_d      = 3'd0;
               state_d    = S_RESP;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         S_RESP: begin
            RES_VALID = 1'b1;
            if (RES_READY) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= S_IDLE;
         cnt_q      <= 3'd0;
         fun_q      <= 4'd0;
         a_q        <= '0;
         b_q        <= '0;
         id_q       <= 1'b0;
         res_data_q <= '0;
         res_id_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         fun_q      <= fun_d;
         a_q        <= a_d;
         b_q        <= b_d;
         id_q       <= id_d;
         res_data_q <= res_data_d;
         res_id_q   <= res_id_d;
      end
   end

`ifndef ALU_SCHED_FIXED_PRIO_EN
   // Round-robin pointer; reset favours REQ0 first
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end
`endif

   assign ALU_FUN  = fun_q;
   assign ALU_A    = a_q;
   assign ALU_B    = b_q;
   assign RES_DATA = res_data_q;
   assign RES_ID   = res_id_q;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Bench for alu_op_scheduler: four instances with ALU_LAT 1..4,
// each driving a behavioural ALU that is only correct in its result cycle.
module tb_alu_op_scheduler;

   logic        clk;
   logic        rst_n;
   logic        v0 [4];
   logic        v1 [4];
   logic        r0 [4];
   logic        r1 [4];
   logic        aen [4];
   logic        rv [4];
   logic        rr [4];
   logic        rid [4];
   logic [3:0]  f0 [4];
   logic [3:0]  f1 [4];
   logic [3:0]  afun [4];
   logic [15:0] a0 [4];
   logic [15:0] b0 [4];
   logic [15:0] a1 [4];
   logic [15:0] b1 [4];
   logic [15:0] aa [4];
   logic [15:0] ab [4];
   logic [15:0] aout [4];
   logic [15:0] rd [4];
   logic        exp_last [4];

   int checks = 0;
   int errors = 0;

   function automatic logic [15:0] alu_fn(logic [3:0] f, logic [15:0] a,
                                          logic [15:0] b);
      case (f[3:2])
         2'd0: return f[0] ? a - b : a + b;
         2'd1: begin
            case (f[1:0])
               2'd0: return a & b;
               2'd1: return a | b;
               2'd2: return a ^ b;
               default: return ~a;
            endcase
         end
         2'd2: return {15'd0, f[0] ? (a == b) : (a < b)};
         default: return f[0] ? (a >> b[3:0]) : (a << b[3:0]);
      endcase
   endfunction

   function automatic logic exp_grant(int i, logic q0, logic q1);
`ifdef ALU_SCHED_FIXED_PRIO_EN
      if (q1 && !q0) return 1'b1;
      return 1'b0;
`else
      if (q0 && q1) return !exp_last[i];
      if (q1) return 1'b1;
      return 1'b0;
`endif
   endfunction

   for (genvar g = 0; g < 4; g++) begin : g_dut
      logic [2:0]  actr;
      logic [15:0] ares;

      alu_op_scheduler #(.WIDTH(16), .ALU_LAT(g + 1)) u_dut (
         .CLK(clk), .RST(rst_n),
         .REQ0_VALID(v0[g]), .REQ0_READY(r0[g]), .REQ0_FUN(f0[g]),
         .REQ0_A(a0[g]), .REQ0_B(b0[g]),
         .REQ1_VALID(v1[g]), .REQ1_READY(r1[g]), .REQ1_FUN(f1[g]),
         .REQ1_A(a1[g]), .REQ1_B(b1[g]),
         .ALU_FUN(afun[g]), .ALU_A(aa[g]), .ALU_B(ab[g]), .ALU_EN(aen[g]),
         .ALU_OUT(aout[g]),
         .RES_VALID(rv[g]), .RES_READY(rr[g]), .RES_DATA(rd[g]),
         .RES_ID(rid[g])
      );

      // ALU model: result valid only in cycle EN+LAT, garbage otherwise
      always @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            actr <= 3'd0;
            ares <= 16'd0;
         end else if (aen[g]) begin
            actr <= 3'(g + 1);
            ares <= alu_fn(afun[g], aa[g], ab[g]);
         end else if (actr != 3'd0) begin
            actr <= actr - 3'd1;
         end
      end

      assign aout[g] = (actr == 3'd1) ? ares : ~ares ^ 16'h5a5a;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic rand_payload(int i, int p);
      if (p == 0) begin
         f0[i] = 4'($urandom);
         a0[i] = 16'($urandom);
         b0[i] = 16'($urandom);
      end else begin
         f1[i] = 4'($urandom);
         a1[i] = 16'($urandom);
         b1[i] = 16'($urandom);
      end
   endtask

   task automatic check_zero(int i, string tag);
      checks++;
      if ({r0[i], r1[i], aen[i], rv[i], rid[i]} !== 5'b0) begin
         errors++;
         $display("FAIL %s_ctl idx=%0d got=%b exp=00000", tag, i,
                  {r0[i], r1[i], aen[i], rv[i], rid[i]});
      end
      checks++;
      if (afun[i] !== 4'd0) begin
         errors++;
         $display("FAIL %s_fun idx=%0d got=%h exp=0", tag, i, afun[i]);
      end
      checks++;
      if (aa[i] !== 16'd0 || ab[i] !== 16'd0) begin
         errors++;
         $display("FAIL %s_ab idx=%0d got=%h/%h exp=0/0", tag, i, aa[i], ab[i]);
      end
      checks++;
      if (rd[i] !== 16'd0) begin
         errors++;
         $display("FAIL %s_rd idx=%0d got=%h exp=0", tag, i, rd[i]);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         v0[i] = 1'b0; v1[i] = 1'b0; rr[i] = 1'b1;
         f0[i] = '0; f1[i] = '0;
         a0[i] = '0; b0[i] = '0; a1[i] = '0; b1[i] = '0;
      end
      cyc(); #1;
      for (int i = 0; i < 4; i++) check_zero(i, "reset");
      cyc();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) exp_last[i] = 1'b1;
      cyc();
   endtask

   task automatic test_single();
      cyc();
      v0[0] = 1'b1; f0[0] = 4'b0000; a0[0] = 16'd5; b0[0] = 16'd3;
      #1;
      checks++;
      if (r0[0] !== 1'b1 || r1[0] !== 1'b0) begin
         errors++;
         $display("FAIL single_rdy got=%b%b exp=10", r0[0], r1[0]);
      end
      exp_last[0] = 1'b0;
      cyc();
      v0[0] = 1'b0;
      #1;
      checks++;
      if (aen[0] !== 1'b1 || rv[0] !== 1'b0) begin
         errors++;
         $display("FAIL single_en got=%b%b exp=10", aen[0], rv[0]);
      end
      checks++;
      if (afun[0] !== 4'd0 || aa[0] !== 16'd5 || ab[0] !== 16'd3) begin
         errors++;
         $display("FAIL single_cmd got=%h/%h/%h exp=0/5/3",
                  afun[0], aa[0], ab[0]);
      end
      cyc(); #1;
      checks++;
      if (aen[0] !== 1'b0 || rv[0] !== 1'b0) begin
         errors++;
         $display("FAIL single_wait got=%b%b exp=00", aen[0], rv[0]);
      end
      cyc(); #1;
      checks++;
      if (rv[0] !== 1'b1 || rd[0] !== 16'd8 || rid[0] !== 1'b0) begin
         errors++;
         $display("FAIL single_res got=%b/%h/%b exp=1/0008/0",
                  rv[0], rd[0], rid[0]);
      end
      cyc(); #1;
      checks++;
      if (rv[0] !== 1'b0) begin
         errors++;
         $display("FAIL single_done got=%b exp=0", rv[0]);
      end
   endtask

   task automatic test_contention();
      int          lat;
      logic        eg;
      logic [15:0] exp;
      lat = 1;
      rand_payload(0, 0);
      rand_payload(0, 1);
      cyc();
      v0[0] = 1'b1; v1[0] = 1'b1; rr[0] = 1'b1;
      for (int g = 0; g < 8; g++) begin
         if (g > 0) cyc();
         #1;
         eg = exp_grant(0, 1'b1, 1'b1);
         checks++;
         if (r0[0] !== !eg || r1[0] !== eg) begin
            errors++;
            $display("FAIL cont_grant n=%0d got=%b%b exp_id=%0d",
                     g, r0[0], r1[0], eg);
         end
         exp = eg ? alu_fn(f1[0], a1[0], b1[0]) : alu_fn(f0[0], a0[0], b0[0]);
         exp_last[0] = eg;
         for (int k = 1; k <= lat + 2; k++) begin
            cyc();
            if (k == 1) rand_payload(0, int'(eg));
            #1;
            checks++;
            if (r0[0] !== 1'b0 || r1[0] !== 1'b0) begin
               errors++;
               $display("FAIL cont_busy n=%0d k=%0d got=%b%b exp=00",
                        g, k, r0[0], r1[0]);
            end
            if (k == lat + 2) begin
               checks++;
               if (rv[0] !== 1'b1 || rd[0] !== exp || rid[0] !== eg) begin
                  errors++;
                  $display("FAIL cont_res n=%0d got=%b/%h/%b exp=1/%h/%b",
                           g, rv[0], rd[0], rid[0], exp, eg);
               end
            end
         end
      end
      v0[0] = 1'b0; v1[0] = 1'b0;
   endtask

   task automatic test_latency_sweep();
      int          lat;
      int          p;
      logic [3:0]  ef;
      logic [15:0] ea;
      logic [15:0] eb;
      logic [15:0] exp;
      for (int i = 0; i < 4; i++) begin
         lat = i + 1;
         for (int rep = 0; rep < 3; rep++) begin
            p = int'($urandom_range(1, 0));
            cyc();
            rand_payload(i, p);
            v0[i] = (p == 0); v1[i] = (p == 1);
            ef = p == 1 ? f1[i] : f0[i];
            ea = p == 1 ? a1[i] : a0[i];
            eb = p == 1 ? b1[i] : b0[i];
            exp = alu_fn(ef, ea, eb);
            #1;
            checks++;
            if (r0[i] !== (p == 0) || r1[i] !== (p == 1)) begin
               errors++;
               $display("FAIL lat_rdy idx=%0d got=%b%b exp_id=%0d",
                        i, r0[i], r1[i], p);
            end
            exp_last[i] = (p == 1);
            for (int k = 1; k <= lat + 2; k++) begin
               cyc();
               if (k == 1) begin
                  v0[i] = 1'b0; v1[i] = 1'b0;
                  rand_payload(i, p);
               end
               #1;
               checks++;
               if (aen[i] !== (k == 1) || rv[i] !== (k == lat + 2)) begin
                  errors++;
                  $display("FAIL lat_ctl idx=%0d k=%0d got=%b%b exp=%b%b",
                           i, k, aen[i], rv[i], k == 1, k == lat + 2);
               end
               if (k <= lat + 1) begin
                  checks++;
                  if (afun[i] !== ef || aa[i] !== ea || ab[i] !== eb) begin
                     errors++;
                     $display("FAIL lat_cmd idx=%0d k=%0d got=%h/%h/%h exp=%h/%h/%h",
                              i, k, afun[i], aa[i], ab[i], ef, ea, eb);
                  end
               end else begin
                  checks++;
                  if (rd[i] !== exp || rid[i] !== (p == 1)) begin
                     errors++;
                     $display("FAIL lat_res idx=%0d got=%h/%b exp=%h/%0d",
                              i, rd[i], rid[i], exp, p);
                  end
               end
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int          lat;
      logic        eg;
      logic [15:0] exp;
      lat = 2;
      cyc();
      rand_payload(1, 1);
      v0[1] = 1'b0; v1[1] = 1'b1; rr[1] = 1'b0;
      exp = alu_fn(f1[1], a1[1], b1[1]);
      #1;
      checks++;
      if (r1[1] !== 1'b1 || r0[1] !== 1'b0) begin
         errors++;
         $display("FAIL bp_rdy got=%b%b exp=01", r0[1], r1[1]);
      end
      exp_last[1] = 1'b1;
      for (int k = 1; k <= lat + 2; k++) begin
         cyc();
         if (k == 1) begin
            rand_payload(1, 0);
            rand_payload(1, 1);
            v0[1] = 1'b1; v1[1] = 1'b1;
         end
         #1;
         checks++;
         if (r0[1] !== 1'b0 || r1[1] !== 1'b0) begin
            errors++;
            $display("FAIL bp_busy k=%0d got=%b%b exp=00", k, r0[1], r1[1]);
         end
      end
      for (int s = 0; s < 10; s++) begin
         cyc(); #1;
         checks++;
         if (rv[1] !== 1'b1 || rd[1] !== exp || rid[1] !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold s=%0d got=%b/%h/%b exp=1/%h/1",
                     s, rv[1], rd[1], rid[1], exp);
         end
         checks++;
         if (r0[1] !== 1'b0 || r1[1] !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall_rdy s=%0d got=%b%b exp=00", s, r0[1], r1[1]);
         end
      end
      cyc();
      rr[1] = 1'b1;
      #1;
      checks++;
      if (rv[1] !== 1'b1 || r0[1] !== 1'b0 || r1[1] !== 1'b0) begin
         errors++;
         $display("FAIL bp_release got=%b%b%b exp=100", rv[1], r0[1], r1[1]);
      end
      cyc(); #1;
      eg = exp_grant(1, 1'b1, 1'b1);
      checks++;
      if (r0[1] !== !eg || r1[1] !== eg || rv[1] !== 1'b0) begin
         errors++;
         $display("FAIL bp_next got=%b%b rv=%b exp_id=%0d",
                  r0[1], r1[1], rv[1], eg);
      end
      exp = eg ? alu_fn(f1[1], a1[1], b1[1]) : alu_fn(f0[1], a0[1], b0[1]);
      exp_last[1] = eg;
      for (int k = 1; k <= lat + 2; k++) begin
         cyc();
         if (k == 1) begin
            v0[1] = 1'b0; v1[1] = 1'b0;
         end
         #1;
         if (k == lat + 2) begin
            checks++;
            if (rv[1] !== 1'b1 || rd[1] !== exp || rid[1] !== eg) begin
               errors++;
               $display("FAIL bp_next_res got=%b/%h/%b exp=1/%h/%b",
                        rv[1], rd[1], rid[1], exp, eg);
            end
         end
      end
   endtask

   task automatic test_drop_valid();
      int lat;
      lat = 3;
      cyc();
      rand_payload(2, 0);
      v0[2] = 1'b1; v1[2] = 1'b0;
      #1;
      checks++;
      if (r0[2] !== 1'b1) begin
         errors++;
         $display("FAIL drop_rdy got=%b exp=1", r0[2]);
      end
      exp_last[2] = 1'b0;
      for (int k = 1; k <= lat + 2; k++) begin
         cyc();
         if (k == 1) begin
            v0[2] = 1'b0; v1[2] = 1'b1;
            rand_payload(2, 1);
         end
         if (k == 2) v1[2] = 1'b0;
         #1;
         checks++;
         if (r0[2] !== 1'b0 || r1[2] !== 1'b0 || rv[2] !== (k == lat + 2)) begin
            errors++;
            $display("FAIL drop_busy k=%0d got=%b%b rv=%b", k, r0[2], r1[2], rv[2]);
         end
      end
      for (int s = 0; s < 3; s++) begin
         cyc(); #1;
         checks++;
         if (aen[2] !== 1'b0 || rv[2] !== 1'b0) begin
            errors++;
            $display("FAIL drop_stale s=%0d got=%b%b exp=00", s, aen[2], rv[2]);
         end
      end
   endtask

   task automatic test_reset_wait();
      int          lat;
      logic        eg;
      logic [15:0] exp;
      lat = 4;
      cyc();
      rand_payload(3, 1);
      v1[3] = 1'b1; v0[3] = 1'b0;
      #1;
      checks++;
      if (r1[3] !== 1'b1) begin
         errors++;
         $display("FAIL rstw_rdy got=%b exp=1", r1[3]);
      end
      cyc();
      v1[3] = 1'b0;
      #1;
      checks++;
      if (aen[3] !== 1'b1) begin
         errors++;
         $display("FAIL rstw_en got=%b exp=1", aen[3]);
      end
      cyc();
      rst_n = 1'b0;
      #1;
      check_zero(3, "rstw_now");
      cyc(); #1;
      check_zero(3, "rstw_hold");
      cyc();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) exp_last[i] = 1'b1;
      rand_payload(3, 0);
      rand_payload(3, 1);
      v0[3] = 1'b1; v1[3] = 1'b1;
      #1;
      eg = exp_grant(3, 1'b1, 1'b1);
      checks++;
      if (r0[3] !== !eg || r1[3] !== eg) begin
         errors++;
         $display("FAIL rstw_first got=%b%b exp_id=%0d", r0[3], r1[3], eg);
      end
      exp = eg ? alu_fn(f1[3], a1[3], b1[3]) : alu_fn(f0[3], a0[3], b0[3]);
      exp_last[3] = eg;
      for (int k = 1; k <= lat + 2; k++) begin
         cyc();
         if (k == 1) begin
            v0[3] = 1'b0; v1[3] = 1'b0;
         end
         #1;
         checks++;
         if (rv[3] !== (k == lat + 2)) begin
            errors++;
            $display("FAIL rstw_rv k=%0d got=%b exp=%b", k, rv[3], k == lat + 2);
         end
         if (k == lat + 2) begin
            checks++;
            if (rd[3] !== exp || rid[3] !== eg) begin
               errors++;
               $display("FAIL rstw_res got=%h/%b exp=%h/%b",
                        rd[3], rid[3], exp, eg);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_latency_sweep();
      test_backpressure();
      test_drop_valid();
      test_reset_wait();
      cyc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
